// File: rtl/display_pkg.sv
// Shared constants for the multiplexed display scanner: default geometry,
// timing and the duty-step derivation used by the on-window logic.
package display_pkg;

   localparam int DEF_NUM_DIGITS       = 4;
   localparam int DEF_DIGIT_W          = 4;
   localparam int DEF_SLOT_CYCLES      = 24000;
   localparam int DEF_DEAD_CYCLES      = 240;
   localparam int DEF_ANODE_ACTIVE_LOW = 1;

   // Brightness is a 4-bit level, so the lit part of a slot is split into 16 steps.
   localparam int DUTY_LEVELS = 16;

   function automatic int calc_on_step(input int slot_cycles, input int dead_cycles);
      return (slot_cycles - dead_cycles) / DUTY_LEVELS;
   endfunction

endpackage

// File: rtl/digit_blank_mask.sv
// Effective dark mask per digit: explicit blank OR leading-zero suppression.
module digit_blank_mask
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int DIGIT_W    = DEF_DIGIT_W
) (
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   input  logic [NUM_DIGITS-1:0]         blank,
   input  logic                          lz_suppress,
   output logic [NUM_DIGITS-1:0]         mask
);

   // zero_from[i]: digits i..NUM_DIGITS-1 are all zero.
   logic [NUM_DIGITS-1:1] zero_from;
   logic [NUM_DIGITS-1:1] lz_flag;

   // Digit 0 always shows, so its value never feeds the suppression chain.
   logic unused_digit0;
   assign unused_digit0 = ^digits[DIGIT_W-1:0];

   assign mask[0] = blank[0];

   genvar gi;
   generate
      for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign zero_from[gi] = (digits[gi*DIGIT_W +: DIGIT_W] == '0);
         end else begin : g_lower
            assign zero_from[gi] = (digits[gi*DIGIT_W +: DIGIT_W] == '0) & zero_from[gi+1];
         end
         assign lz_flag[gi] = lz_suppress & zero_from[gi];
         assign mask[gi]    = blank[gi] | lz_flag[gi];
      end
   endgenerate

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed digit scanner: per-slot anode drive with dead time and
// brightness duty, frame-aligned input snapshot, registered outputs.
module digit_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS       = DEF_NUM_DIGITS,
   parameter int DIGIT_W          = DEF_DIGIT_W,
   parameter int SLOT_CYCLES      = DEF_SLOT_CYCLES,
   parameter int DEAD_CYCLES      = DEF_DEAD_CYCLES,
   parameter int ANODE_ACTIVE_LOW = DEF_ANODE_ACTIVE_LOW
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_i,
   input  logic [NUM_DIGITS-1:0]           blank_i,
   input  logic                            lz_suppress_i,
   input  logic [3:0]                      brightness_i,
   output logic [DIGIT_W-1:0]              seg_val_o,
   output logic [NUM_DIGITS-1:0]           anode_o,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx_o,
   output logic                            frame_start_o
);

   localparam int   ON_STEP    = calc_on_step(SLOT_CYCLES, DEAD_CYCLES);
   localparam int   CNT_W      = $clog2(SLOT_CYCLES);
   localparam int   IDX_W      = $clog2(NUM_DIGITS);
   localparam int   END_W      = CNT_W + 1;
   localparam logic ACTIVE_LVL = (ANODE_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [END_W-1:0] DEAD_END  = END_W'(DEAD_CYCLES);
   localparam logic [END_W-1:0] STEP_E    = END_W'(ON_STEP);

   logic [CNT_W-1:0] slot_cnt_reg, slot_cnt_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             slot_wrap, frame_last;

   logic [NUM_DIGITS*DIGIT_W-1:0] digits_snap_reg;
   logic [NUM_DIGITS-1:0]         blank_snap_reg;
   logic                          lz_snap_reg;
   logic [3:0]                    bright_snap_reg;

   logic [NUM_DIGITS-1:0] dark_mask;
   logic [DIGIT_W-1:0]    digit_val [NUM_DIGITS];
   logic [END_W-1:0]      slot_ext, on_end;
   logic                  on_window;
   logic [NUM_DIGITS-1:0] anode_next;

   logic [NUM_DIGITS-1:0] anode_reg;
   logic [DIGIT_W-1:0]    seg_val_reg;
   logic [IDX_W-1:0]      idx_out_reg;
   logic                  frame_start_reg;

   always_comb begin
      slot_wrap     = (slot_cnt_reg == SLOT_LAST);
      frame_last    = slot_wrap && (idx_reg == IDX_LAST);
      slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
      idx_next      = idx_reg;
      if (slot_wrap) begin
         idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_reg <= '0;
         idx_reg      <= '0;
      end else begin
         slot_cnt_reg <= slot_cnt_next;
         idx_reg      <= idx_next;
      end
   end

   // Inputs are only sampled on the last cycle of a frame, so a frame is never torn.
   always_ff @(posedge clk) begin
      if (reset) begin
         digits_snap_reg <= '0;
         blank_snap_reg  <= '1;
         lz_snap_reg     <= 1'b0;
         bright_snap_reg <= '0;
      end else if (frame_last) begin
         digits_snap_reg <= digits_i;
         blank_snap_reg  <= blank_i;
         lz_snap_reg     <= lz_suppress_i;
         bright_snap_reg <= brightness_i;
      end
   end

   digit_blank_mask #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIGIT_W    (DIGIT_W)
   ) u_blank_mask (
      .digits      (digits_snap_reg),
      .blank       (blank_snap_reg),
      .lz_suppress (lz_snap_reg),
      .mask        (dark_mask)
   );

   // Lit for ON_STEP*(brightness+1) cycles right after the dead time.
   always_comb begin
      slot_ext  = {1'b0, slot_cnt_reg};
      on_end    = DEAD_END + STEP_E * (END_W'(bright_snap_reg) + END_W'(1));
      on_window = (slot_ext >= DEAD_END) && (slot_ext < on_end);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
         assign digit_val[gi]  = digits_snap_reg[gi*DIGIT_W +: DIGIT_W];
         assign anode_next[gi] = (on_window && (idx_reg == IDX_W'(gi)) && !dark_mask[gi])
                                 ? ACTIVE_LVL : ~ACTIVE_LVL;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         anode_reg       <= {NUM_DIGITS{~ACTIVE_LVL}};
         seg_val_reg     <= '0;
         idx_out_reg     <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         anode_reg       <= anode_next;
         seg_val_reg     <= digit_val[idx_reg];
         idx_out_reg     <= idx_reg;
         frame_start_reg <= (slot_cnt_reg == '0) && (idx_reg == '0);
      end
   end

   assign anode_o       = anode_reg;
   assign seg_val_o     = seg_val_reg;
   assign digit_idx_o   = idx_out_reg;
   assign frame_start_o = frame_start_reg;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with a 36-cycle slot, 4-cycle dead time, 4 digits.
module tb_digit_scanner;

   localparam int FRAME = 144;

   logic        clk;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        lz_suppress;
   logic [3:0]  brightness;
   logic [3:0]  seg_val;
   logic [3:0]  anode;
   logic [1:0]  digit_idx;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   logic [3:0] cap_anode [FRAME];
   logic [3:0] cap_seg   [FRAME];
   logic [1:0] cap_idx   [FRAME];
   logic       cap_fs    [FRAME];

   digit_scanner #(
      .NUM_DIGITS       (4),
      .DIGIT_W          (4),
      .SLOT_CYCLES      (36),
      .DEAD_CYCLES      (4),
      .ANODE_ACTIVE_LOW (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .digits_i      (digits),
      .blank_i       (blank),
      .lz_suppress_i (lz_suppress),
      .brightness_i  (brightness),
      .seg_val_o     (seg_val),
      .anode_o       (anode),
      .digit_idx_o   (digit_idx),
      .frame_start_o (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records outputs for output cycles 0..stop_at-1 of the current frame.
   task automatic capture(input int stop_at, input int chg_at, input logic [15:0] chg_digits);
      for (int n = 0; n < stop_at; n++) begin
         @(posedge clk);
         #1;
         cap_anode[n] = anode;
         cap_seg[n]   = seg_val;
         cap_idx[n]   = digit_idx;
         cap_fs[n]    = frame_start;
         if (n == chg_at) digits = chg_digits;
      end
   endtask

   // Expected active-low anodes: lit for slot_cnt 4 .. 4+2*(bright+1)-1 unless dark.
   function automatic logic [3:0] exp_anode(input int n, input int bright, input logic [3:0] dark);
      int slot;
      int k;
      logic [3:0] a;
      slot = n % 36;
      k    = n / 36;
      a    = 4'b1111;
      if (slot >= 4 && slot < 4 + 2 * (bright + 1) && !dark[k]) a[k] = 1'b0;
      return a;
   endfunction

   task automatic test_reset();
      digits = 16'h4321; blank = 4'b0000; lz_suppress = 1'b0; brightness = 4'd15;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode: actual %b expected 1111", anode); end
      checks++; if (seg_val !== 4'h0) begin errors++; $display("FAIL reset_seg: actual %h expected 0", seg_val); end
      checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: actual %0d expected 0", digit_idx); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: actual %b expected 0", frame_start); end
      @(negedge clk);
      reset = 1'b0;
      $display("reset: outputs idle during reset");
   endtask

   task automatic test_dark_first_frame();
      int bad = 0;
      int seg_bad = 0;
      int fs_cnt = 0;
      capture(FRAME, -1, 16'h0);
      for (int n = 0; n < FRAME; n++) begin
         if (cap_anode[n] !== 4'b1111) bad++;
         if (cap_seg[n] !== 4'h0) seg_bad++;
         if (cap_fs[n] === 1'b1) fs_cnt++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL first_frame_dark: actual %0d lit cycles expected 0", bad); end
      checks++; if (seg_bad != 0) begin errors++; $display("FAIL first_frame_seg: actual %0d nonzero cycles expected 0", seg_bad); end
      checks++; if (cap_fs[0] !== 1'b1 || fs_cnt != 1) begin errors++; $display("FAIL first_frame_fs: actual fs0=%b count=%0d expected 1/1", cap_fs[0], fs_cnt); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_idx[36*k+20] !== 2'(k)) begin errors++; $display("FAIL first_frame_idx%0d: actual %0d expected %0d", k, cap_idx[36*k+20], k); end
      end
      $display("first frame: dark %0d bad, fs count %0d", bad, fs_cnt);
   endtask

   task automatic test_full_bright();
      capture(FRAME, -1, 16'h0);
      for (int k = 0; k < 4; k++) begin
         int bad = 0;
         int seg_bad = 0;
         for (int s = 0; s < 36; s++) begin
            if (cap_anode[36*k+s] !== exp_anode(36*k+s, 15, 4'b0000)) bad++;
            if (cap_seg[36*k+s] !== 4'(k + 1)) seg_bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL full_bright_anode%0d: actual %0d wrong cycles expected 0", k, bad); end
         checks++; if (seg_bad != 0) begin errors++; $display("FAIL full_bright_seg%0d: actual %h expected %0d", k, cap_seg[36*k+10], k + 1); end
      end
      $display("full brightness frame checked, digits 4321");
   endtask

   task automatic test_brightness();
      int levels [2] = '{0, 7};
      int lit_req [2] = '{2, 16};
      for (int l = 0; l < 2; l++) begin
         int bad = 0;
         brightness = 4'(levels[l]);
         capture(FRAME, -1, 16'h0);
         capture(FRAME, -1, 16'h0);
         for (int n = 0; n < FRAME; n++)
            if (cap_anode[n] !== exp_anode(n, levels[l], 4'b0000)) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL bright%0d_pattern: actual %0d wrong cycles expected 0", levels[l], bad); end
         for (int k = 0; k < 4; k++) begin
            int lit = 0;
            for (int s = 0; s < 36; s++) if (cap_anode[36*k+s][k] === 1'b0) lit++;
            checks++; if (lit != lit_req[l]) begin errors++; $display("FAIL bright%0d_lit%0d: actual %0d expected %0d", levels[l], k, lit, lit_req[l]); end
         end
         $display("brightness %0d: pattern errors %0d", levels[l], bad);
      end
      brightness = 4'd15;
   endtask

   task automatic test_lz();
      logic [15:0] vals [2] = '{16'h0050, 16'h0000};
      logic [3:0]  dark [2] = '{4'b1100, 4'b1110};
      lz_suppress = 1'b1;
      for (int v = 0; v < 2; v++) begin
         int bad = 0;
         digits = vals[v];
         capture(FRAME, -1, 16'h0);
         capture(FRAME, -1, 16'h0);
         for (int n = 0; n < FRAME; n++)
            if (cap_anode[n] !== exp_anode(n, 15, dark[v])) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL lz_%h_pattern: actual %0d wrong cycles expected 0", vals[v], bad); end
         $display("leading zeros digits=%h: pattern errors %0d", vals[v], bad);
      end
      digits = 16'h0050;
      capture(FRAME, -1, 16'h0);
      capture(FRAME, -1, 16'h0);
      checks++; if (cap_seg[36+10] !== 4'h5) begin errors++; $display("FAIL lz_seg1: actual %h expected 5", cap_seg[46]); end
      checks++; if (cap_seg[10] !== 4'h0) begin errors++; $display("FAIL lz_seg0: actual %h expected 0", cap_seg[10]); end
      checks++; if (cap_seg[108+10] !== 4'h0) begin errors++; $display("FAIL lz_seg3: actual %h expected 0", cap_seg[118]); end
      lz_suppress = 1'b0;
   endtask

   task automatic test_snapshot();
      int seg_bad = 0;
      int fs_cnt = 0;
      digits = 16'h1111;
      capture(FRAME, -1, 16'h0);
      capture(FRAME, 50, 16'h2222);
      for (int n = 0; n < FRAME; n++) begin
         if (cap_seg[n] !== 4'h1) seg_bad++;
         if (cap_fs[n] === 1'b1) fs_cnt++;
      end
      checks++; if (seg_bad != 0) begin errors++; $display("FAIL snap_current: actual %0d cycles not 1 expected 0", seg_bad); end
      checks++; if (fs_cnt != 1 || cap_fs[0] !== 1'b1) begin errors++; $display("FAIL snap_fs_a: actual count %0d expected 1", fs_cnt); end
      seg_bad = 0;
      fs_cnt = 0;
      capture(FRAME, -1, 16'h0);
      for (int n = 0; n < FRAME; n++) begin
         if (cap_seg[n] !== 4'h2) seg_bad++;
         if (cap_fs[n] === 1'b1) fs_cnt++;
      end
      checks++; if (seg_bad != 0) begin errors++; $display("FAIL snap_next: actual %0d cycles not 2 expected 0", seg_bad); end
      checks++; if (fs_cnt != 1 || cap_fs[0] !== 1'b1) begin errors++; $display("FAIL snap_fs_b: actual count %0d expected 1", fs_cnt); end
      $display("snapshot: mid-frame change deferred to next frame");
   endtask

   task automatic test_blank();
      int bad = 0;
      int seg_bad = 0;
      int a2_on = 0;
      digits = 16'h3210;
      blank = 4'b0100;
      capture(FRAME, -1, 16'h0);
      capture(FRAME, -1, 16'h0);
      for (int n = 0; n < FRAME; n++) begin
         if (cap_anode[n] !== exp_anode(n, 15, 4'b0100)) bad++;
         if (cap_anode[n][2] === 1'b0) a2_on++;
      end
      for (int s = 72; s < 108; s++) if (cap_seg[s] !== 4'h2) seg_bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL blank_pattern: actual %0d wrong cycles expected 0", bad); end
      checks++; if (a2_on != 0) begin errors++; $display("FAIL blank_anode2: actual %0d active cycles expected 0", a2_on); end
      checks++; if (seg_bad != 0) begin errors++; $display("FAIL blank_seg2: actual %h expected 2", cap_seg[80]); end
      $display("blank digit 2: pattern errors %0d", bad);
   endtask

   task automatic test_reset_midframe();
      int bad = 0;
      blank = 4'b0000;
      capture(FRAME, -1, 16'h0);
      capture(82, -1, 16'h0);
      checks++; if (cap_anode[81] !== 4'b1011) begin errors++; $display("FAIL midreset_pre: actual %b expected 1011", cap_anode[81]); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL midreset_anode: actual %b expected 1111", anode); end
      checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL midreset_idx: actual %0d expected 0", digit_idx); end
      checks++; if (seg_val !== 4'h0) begin errors++; $display("FAIL midreset_seg: actual %h expected 0", seg_val); end
      @(negedge clk);
      reset = 1'b0;
      capture(FRAME, -1, 16'h0);
      for (int n = 0; n < FRAME; n++) if (cap_anode[n] !== 4'b1111) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL midreset_dark: actual %0d lit cycles expected 0", bad); end
      checks++; if (cap_fs[0] !== 1'b1) begin errors++; $display("FAIL midreset_fs: actual %b expected 1", cap_fs[0]); end
      $display("mid-frame reset: dark frame lit cycles %0d", bad);
   endtask

   initial begin
      reset = 1'b1;
      digits = '0; blank = '0; lz_suppress = 1'b0; brightness = '0;
      test_reset();
      test_dark_first_frame();
      test_full_bright();
      test_brightness();
      test_lz();
      test_snapshot();
      test_blank();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; SHALL be >= 2.
REQ-002 Parameter DIGIT_W, default 4, bits per digit value.
REQ-003 Parameter SLOT_CYCLES, default 24000, clk cycles per digit slot; SHALL be >= DEAD_CYCLES+16.
REQ-004 Parameter DEAD_CYCLES, default 240, anti-ghosting all-off cycles at slot start.
REQ-005 Parameter ANODE_ACTIVE_LOW, default 1, anode_o drive polarity.
REQ-006 Port clk, input, 1, the single system clock.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port digits_i, input, NUM_DIGITS*DIGIT_W; digit i = bits [i*DIGIT_W +: DIGIT_W], digit 0 least significant.
REQ-009 Port blank_i, input, NUM_DIGITS; bit i=1 forces digit i dark.
REQ-010 Port lz_suppress_i, input, 1; enables leading-zero blanking.
REQ-011 Port brightness_i, input, 4; duty level 0..15.
REQ-012 Port seg_val_o, output, DIGIT_W; value of the digit currently scanned, for the downstream segment decoder.
REQ-013 Port anode_o, output, NUM_DIGITS; at most one bit at active level at any time.
REQ-014 Port digit_idx_o, output, clog2(NUM_DIGITS); index of the scanned digit.
REQ-015 Port frame_start_o, output, 1; one-cycle pulse at frame start.

Function
REQ-016 slot_cnt SHALL count 0..SLOT_CYCLES-1 every clk and wrap to 0; idx SHALL advance 0..NUM_DIGITS-1 on each wrap, then wrap to 0.
REQ-017 Snapshot registers (digits, blank, lz_suppress, brightness) SHALL load from inputs only in the cycle where slot_cnt==SLOT_CYCLES-1 and idx==NUM_DIGITS-1; mid-frame input changes SHALL NOT affect the current frame.
REQ-018 ON_STEP = (SLOT_CYCLES-DEAD_CYCLES)/16 (integer, compile-time constant).
REQ-019 On-window: DEAD_CYCLES <= slot_cnt < DEAD_CYCLES + ON_STEP*(brightness+1); brightness 15 SHALL reach the slot end when divisible, with no remaining cycles lit.
REQ-020 Effective blank for digit i = snapshot blank[i] OR leading-zero flag[i].
REQ-021 Leading-zero flag[i] SHALL be 1 iff lz_suppress set, i >= 1, and snapshot digits i..NUM_DIGITS-1 all equal 0; digit 0 is never lz-blanked.
REQ-022 anode_o[idx] SHALL be active iff in on-window and digit idx not effectively blanked; all other bits inactive.
REQ-023 seg_val_o SHALL carry snapshot digit idx regardless of blanking.
REQ-024 All outputs SHALL be registered with exactly 1 cycle latency from the counter state.
REQ-025 frame_start_o SHALL be 1 in the output cycle corresponding to slot_cnt==0, idx==0, else 0.
REQ-026 Active level = 0 when ANODE_ACTIVE_LOW=1, else 1.

Reset
REQ-027 reset SHALL clear slot_cnt, idx, snapshot digits, snapshot brightness and lz_suppress to 0, and set snapshot blank to all-ones.
REQ-028 During reset and the cycle after, anode_o SHALL be all inactive, seg_val_o=0, digit_idx_o=0, frame_start_o=0.
REQ-029 First frame after reset SHALL be fully dark; new inputs appear from the second frame.
REQ-030 reset asserted mid-frame SHALL abort the scan immediately; no partial-slot anode activity after the reset edge.

Structure
REQ-031 Shared package display_pkg SHALL hold default parameter constants and the ON_STEP derivation.
REQ-032 Blank/leading-zero mask logic SHALL be a combinational sub-module digit_blank_mask (inputs snapshot digits, blank, lz_suppress; output effective mask).

Verification (NUM_DIGITS=4, DIGIT_W=4, SLOT_CYCLES=36, DEAD_CYCLES=4, ON_STEP=2, ANODE_ACTIVE_LOW=1)
REQ-033 Reset, digits=0x4321, blank=0, bright=15 -> frame 1 anode_o=4'b1111 throughout; frame 2 slot k: anode_o[k]=0 for slot_cnt 4..35, seg_val_o=k+1.
REQ-034 bright=0 -> each digit lit exactly 2 cycles per slot (slot_cnt 4,5); bright=7 -> 16 cycles.
REQ-035 digits=0x0050, lz_suppress=1 -> digits 3,2 dark, digits 1,0 lit (values 5, 0); digits=0x0000 -> only digit 0 lit.
REQ-036 Change digits from 0x1111 to 0x2222 mid-frame -> current frame shows 1s, next frame 2s; frame_start_o pulses once per 144 cycles.
REQ-037 blank=4'b0100 -> anode_o[2] never active, seg_val_o still 2 during slot 2 for digits=0x3210.
REQ-038 reset asserted at slot 2 cycle 10 -> next cycle anode_o=4'b1111, digit_idx_o=0, then full dark frame.
